// File: rtl/noc_link_tx.sv
// Transmit end of a credit-based NoC link: pops a show-ahead FIFO onto a
// registered link, tracks downstream credits and checks packet framing.
module noc_link_tx #(
    parameter int WIDTH   = 32,
    parameter int CREDITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             fifo_data,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic                         tx_en,
    output logic                         flit_valid,
    output logic [WIDTH-1:0]             flit_data,
    input  logic                         credit_in,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
    output logic                         pkt_active,
    output logic                         err_proto,
    output logic                         err_credit
);

    localparam int CW = $clog2(CREDITS + 1);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    state_t          state;
    state_t          state_next;
    logic            send;
    logic [1:0]      ftype;
    logic            proto_bad;
    logic            credit_over;
    logic [CW-1:0]   cnt_next;

    assign ftype      = fifo_data[WIDTH-1:WIDTH-2];
    assign send       = tx_en && !fifo_empty && (credit_cnt != '0);
    assign fifo_rd_en = send;
    assign pkt_active = (state == IN_PKT);

    // A returned credit with nothing sent and a full count is an overflow.
    always_comb begin
        cnt_next    = credit_cnt;
        credit_over = 1'b0;
        if (send && !credit_in) begin
            cnt_next = credit_cnt - 1'b1;
        end else if (!send && credit_in) begin
            if (credit_cnt == CW'(CREDITS)) begin
                credit_over = 1'b1;
            end else begin
                cnt_next = credit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        proto_bad  = 1'b0;
        if (send) begin
            case (state)
                IDLE: begin
                    case (ftype)
                        T_HEAD:   state_next = IN_PKT;
                        T_SINGLE: state_next = IDLE;
                        T_BODY,
                        T_TAIL:   proto_bad  = 1'b1;
                        default:  proto_bad  = 1'b1;
                    endcase
                end
                IN_PKT: begin
                    case (ftype)
                        T_BODY:   state_next = IN_PKT;
                        T_TAIL:   state_next = IDLE;
                        T_HEAD,
                        T_SINGLE: proto_bad  = 1'b1;
                        default:  proto_bad  = 1'b1;
                    endcase
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            flit_valid <= 1'b0;
            flit_data  <= '0;
            credit_cnt <= CW'(CREDITS);
            err_proto  <= 1'b0;
            err_credit <= 1'b0;
        end else begin
            state      <= state_next;
            flit_valid <= send;
            credit_cnt <= cnt_next;
            if (send) begin
                flit_data <= fifo_data;
            end
            if (proto_bad) begin
                err_proto <= 1'b1;
            end
            if (credit_over) begin
                err_credit <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_link_tx.sv
// Bench for noc_link_tx: directed vector table, reset corner cases and
// randomized traffic against a queue-based reference model.
module tb_noc_link_tx;

    localparam int W = 32;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] fifo_data;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic         tx_en;
    logic         flit_valid;
    logic [W-1:0] flit_data;
    logic         credit_in;
    logic [2:0]   credit_cnt;
    logic         pkt_active;
    logic         err_proto;
    logic         err_credit;

    int total = 0;
    int bad   = 0;

    noc_link_tx #(.WIDTH(W), .CREDITS(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx_en      (tx_en),
        .flit_valid (flit_valid),
        .flit_data  (flit_data),
        .credit_in  (credit_in),
        .credit_cnt (credit_cnt),
        .pkt_active (pkt_active),
        .err_proto  (err_proto),
        .err_credit (err_credit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tx;
        logic        empty;
        logic        cin;
        logic [31:0] data;
        logic        e_rd;
        logic        e_valid;
        logic [31:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_pkt;
        logic        e_ep;
        logic        e_ec;
    } vec_t;

    vec_t tab[14];

    // reference model state
    logic [W-1:0] q[$];
    int           m_cred;
    bit           m_inpkt;
    bit           m_ep;
    bit           m_ec;
    bit           m_valid;
    logic [W-1:0] m_data;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cred  = C;
        m_inpkt = 0;
        m_ep    = 0;
        m_ec    = 0;
        m_valid = 0;
        m_data  = '0;
        q.delete();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        tx_en      = 1'b0;
        credit_in  = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic tstep(input vec_t v, input int idx);
        tx_en      = v.tx;
        fifo_empty = v.empty;
        credit_in  = v.cin;
        fifo_data  = v.data;
        @(negedge clk);
        chk($sformatf("tab%0d rd_en", idx), fifo_rd_en, v.e_rd);
        @(posedge clk);
        #1;
        chk($sformatf("tab%0d valid", idx), flit_valid, v.e_valid);
        chk($sformatf("tab%0d data", idx), flit_data, v.e_data);
        chk($sformatf("tab%0d cnt", idx), credit_cnt, v.e_cnt);
        chk($sformatf("tab%0d pkt", idx), pkt_active, v.e_pkt);
        chk($sformatf("tab%0d err_proto", idx), err_proto, v.e_ep);
        chk($sformatf("tab%0d err_credit", idx), err_credit, v.e_ec);
    endtask

    // One cycle of traffic from the queue, checked against the model.
    task automatic mstep(input bit tx, input bit cin, input string nm);
        bit  snd;
        bit  starts;
        bit  ends;
        bit  ferr;
        int  nc;
        tx_en      = tx;
        credit_in  = cin;
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : '0;
        snd = tx && (q.size() != 0) && (m_cred > 0);
        @(negedge clk);
        chk({nm, " rd_en"}, fifo_rd_en, snd);
        m_valid = snd;
        if (snd) begin
            // type bit0: flit opens a packet, bit1: flit closes one
            starts = q[0][W-2];
            ends   = q[0][W-1];
            ferr   = (starts == m_inpkt);
            if (ferr) m_ep = 1;
            else m_inpkt = !ends;
            m_data = q[0];
        end
        nc = m_cred - int'(snd) + int'(cin);
        if (nc > C) begin
            m_ec = 1;
            nc   = C;
        end
        m_cred = nc;
        @(posedge clk);
        #1;
        if (snd) void'(q.pop_front());
        chk({nm, " valid"}, flit_valid, m_valid);
        chk({nm, " data"}, flit_data, m_data);
        chk({nm, " cnt"}, credit_cnt, m_cred);
        chk({nm, " pkt"}, pkt_active, m_inpkt);
        chk({nm, " err_proto"}, err_proto, m_ep);
        chk({nm, " err_credit"}, err_credit, m_ec);
    endtask

    initial begin
        int npop;
        tab[0]  = '{1,0,0,32'h4000_0001, 1,1,32'h4000_0001,3'd3,1,0,0};
        tab[1]  = '{1,0,0,32'h0000_0002, 1,1,32'h0000_0002,3'd2,1,0,0};
        tab[2]  = '{1,0,1,32'h8000_0003, 1,1,32'h8000_0003,3'd2,0,0,0};
        tab[3]  = '{1,0,0,32'h0000_0004, 1,1,32'h0000_0004,3'd1,0,1,0};
        tab[4]  = '{1,1,1,32'h0000_0000, 0,0,32'h0000_0004,3'd2,0,1,0};
        tab[5]  = '{1,1,1,32'h0000_0000, 0,0,32'h0000_0004,3'd3,0,1,0};
        tab[6]  = '{1,1,1,32'h0000_0000, 0,0,32'h0000_0004,3'd4,0,1,0};
        tab[7]  = '{1,1,1,32'h0000_0000, 0,0,32'h0000_0004,3'd4,0,1,1};
        tab[8]  = '{1,0,0,32'h4000_00AA, 1,1,32'h4000_00AA,3'd3,1,1,1};
        tab[9]  = '{0,0,0,32'h0000_00BB, 0,0,32'h4000_00AA,3'd3,1,1,1};
        tab[10] = '{0,0,1,32'h0000_00BB, 0,0,32'h4000_00AA,3'd4,1,1,1};
        tab[11] = '{1,0,0,32'h0000_00BB, 1,1,32'h0000_00BB,3'd3,1,1,1};
        tab[12] = '{1,0,0,32'hC000_00CC, 1,1,32'hC000_00CC,3'd2,1,1,1};
        tab[13] = '{1,0,0,32'h8000_00DD, 1,1,32'h8000_00DD,3'd1,0,1,1};

        // reset with tx_en high and FIFO empty
        rst_n      = 1'b0;
        tx_en      = 1'b1;
        credit_in  = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid", flit_valid, 0);
        chk("rst data", flit_data, 0);
        chk("rst cnt", credit_cnt, C);
        chk("rst rd_en", fifo_rd_en, 0);
        chk("rst pkt", pkt_active, 0);
        chk("rst err_proto", err_proto, 0);
        chk("rst err_credit", err_credit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tab[i]) tstep(tab[i], i);

        // six singles, no credit returns: only four go out
        do_reset();
        for (int i = 0; i < 6; i++) q.push_back({2'b11, 30'(i + 16)});
        npop = 0;
        for (int i = 0; i < 6; i++) begin
            mstep(1, 0, $sformatf("burst%0d", i));
            if (m_valid) npop++;
        end
        chk("burst pops", npop, 4);
        chk("burst left", q.size(), 2);
        mstep(1, 1, "cret");
        mstep(1, 0, "cret pop");
        chk("cret data", flit_data, {2'b11, 30'd20});
        mstep(1, 0, "cret idle");

        // reset while mid-packet with one credit left
        do_reset();
        q.push_back(32'h4000_0010);
        q.push_back(32'h0000_0011);
        q.push_back(32'h0000_0012);
        for (int i = 0; i < 3; i++) mstep(1, 0, $sformatf("pre%0d", i));
        chk("pre pkt", pkt_active, 1);
        chk("pre cnt", credit_cnt, 1);
        tx_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst valid", flit_valid, 0);
        chk("arst cnt", credit_cnt, C);
        chk("arst pkt", pkt_active, 0);
        chk("arst errs", {err_proto, err_credit}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        q.push_back(32'h0000_0013);
        mstep(1, 0, "post body");
        chk("post err_proto", err_proto, 1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 60) q.push_back($urandom);
            if (i == 200) begin
                do_reset();
            end
            mstep($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                  $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
